// File: rtl/run_ctrl_pkg.sv
// rtl/run_ctrl_pkg.sv - shared state encoding and default parameters for run_controller
package run_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RST  = 3'd1,
    ST_ARM  = 3'd2,
    ST_RUN  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  localparam int DEF_RESET_CYCLES = 2;
  localparam int DEF_MAX_CYCLES   = 250;
  localparam int DEF_CNT_W        = 16;
  localparam int DEF_NUM_CORES    = 1;

endpackage

// File: rtl/run_controller_if.sv
// rtl/run_controller_if.sv - run request, halt and status bundle between harness and run_controller
interface run_controller_if #(
  parameter int NUM_CORES = run_ctrl_pkg::DEF_NUM_CORES,
  parameter int CNT_W     = run_ctrl_pkg::DEF_CNT_W
);

  logic                 go;
  logic [NUM_CORES-1:0] halted;
  logic                 core_reset;
  logic                 start;
  logic                 running;
  logic                 done;
  logic                 timeout;
  logic [CNT_W-1:0]     cycle_count;
  logic [NUM_CORES-1:0] halted_mask;

  modport master (
    output go, halted,
    input  core_reset, start, running, done, timeout, cycle_count, halted_mask
  );

  modport slave (
    input  go, halted,
    output core_reset, start, running, done, timeout, cycle_count, halted_mask
  );

endinterface

// File: rtl/run_controller_sat_counter.sv
// rtl/run_controller_sat_counter.sv - up-counter with synchronous clear, enable and saturation at all-ones
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/run_controller.sv
// rtl/run_controller.sv - sequences core reset release, start, cycle counting and run termination
module run_controller
  import run_ctrl_pkg::*;
#(
  parameter int RESET_CYCLES = DEF_RESET_CYCLES,
  parameter int MAX_CYCLES   = DEF_MAX_CYCLES,
  parameter int CNT_W        = DEF_CNT_W,
  parameter int NUM_CORES    = DEF_NUM_CORES
) (
  input  logic             clock,
  input  logic             reset,
  run_controller_if.slave  bus
);

  localparam int RW = $clog2(RESET_CYCLES + 1);

  state_t               state_q, state_d;
  logic                 core_reset_q, core_reset_d;
  logic                 run_q, run_d;
  logic                 done_q, done_d;
  logic                 timeout_q, timeout_d;
  logic [NUM_CORES-1:0] halted_mask_q, halted_mask_d;
  logic [CNT_W-1:0]     cycle_count;
  logic [RW-1:0]        rst_cnt;
  logic                 rst_entry;
  logic                 all_h;

  always_comb begin
    state_d       = state_q;
    timeout_d     = timeout_q;
    halted_mask_d = halted_mask_q;
    all_h         = &(halted_mask_q | bus.halted);
    case (state_q)
      ST_IDLE: if (bus.go) state_d = ST_RST;
      ST_RST:  if (rst_cnt == RW'(RESET_CYCLES - 1)) state_d = ST_ARM;
      ST_ARM:  state_d = ST_RUN;
      ST_RUN: begin
        halted_mask_d = halted_mask_q | bus.halted;
        // Halt is checked first so a halt on the limit cycle is not a timeout.
        if (all_h) begin
          state_d = ST_DONE;
        end else if (cycle_count == CNT_W'(MAX_CYCLES - 1)) begin
          state_d   = ST_DONE;
          timeout_d = 1'b1;
        end
      end
      ST_DONE: if (bus.go) state_d = ST_RST;
      default: state_d = ST_IDLE;
    endcase

    rst_entry = (state_d == ST_RST) && (state_q != ST_RST);
    if (rst_entry) begin
      timeout_d     = 1'b0;
      halted_mask_d = '0;
    end

    core_reset_d = (state_d == ST_IDLE) || (state_d == ST_RST);
    run_d        = (state_d == ST_RUN);
    done_d       = (state_d == ST_DONE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      core_reset_q  <= 1'b1;
      run_q         <= 1'b0;
      done_q        <= 1'b0;
      timeout_q     <= 1'b0;
      halted_mask_q <= '0;
    end else begin
      state_q       <= state_d;
      core_reset_q  <= core_reset_d;
      run_q         <= run_d;
      done_q        <= done_d;
      timeout_q     <= timeout_d;
      halted_mask_q <= halted_mask_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk (clock),
    .rst (reset),
    .clr (rst_entry),
    .en  (state_q == ST_RUN),
    .q   (cycle_count)
  );

  sat_counter #(.W(RW)) u_rst_cnt (
    .clk (clock),
    .rst (reset),
    .clr (rst_entry),
    .en  (state_q == ST_RST),
    .q   (rst_cnt)
  );

  assign bus.core_reset  = core_reset_q;
  assign bus.start       = run_q;
  assign bus.running     = run_q;
  assign bus.done        = done_q;
  assign bus.timeout     = timeout_q;
  assign bus.cycle_count = cycle_count;
  assign bus.halted_mask = halted_mask_q;

endmodule

// File: tb/tb_run_controller.sv
// tb/tb_run_controller.sv - directed self-checking bench for run_controller
module tb_run_controller;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   passed = 0;
  logic [4:0] fl;

  always #5 clk = ~clk;

  run_controller_if #(.NUM_CORES(1), .CNT_W(16)) bus_a ();
  run_controller_if #(.NUM_CORES(3), .CNT_W(16)) bus_b ();

  run_controller #(.RESET_CYCLES(2), .MAX_CYCLES(250), .CNT_W(16), .NUM_CORES(1)) dut_a (
    .clock (clk), .reset (rst), .bus (bus_a)
  );

  run_controller #(.RESET_CYCLES(2), .MAX_CYCLES(20), .CNT_W(16), .NUM_CORES(3)) dut_b (
    .clock (clk), .reset (rst), .bus (bus_b)
  );

  // {core_reset, start, running, done, timeout}
  function automatic logic [4:0] fa();
    return {bus_a.core_reset, bus_a.start, bus_a.running, bus_a.done, bus_a.timeout};
  endfunction

  function automatic logic [4:0] fb();
    return {bus_b.core_reset, bus_b.start, bus_b.running, bus_b.done, bus_b.timeout};
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus_a.go = 1'b0; bus_a.halted = '0;
    bus_b.go = 1'b0; bus_b.halted = '0;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic start_a();
    bus_a.go = 1'b1; tick(1); bus_a.go = 1'b0; tick(3);
  endtask

  task automatic start_b();
    bus_b.go = 1'b1; tick(1); bus_b.go = 1'b0; tick(3);
  endtask

  task automatic test_reset();
    do_reset();
    fl = fa(); total++;
    if (fl !== 5'b10000) $display("FAIL reset_a_flags got %b want %b", fl, 5'b10000); else passed++;
    total++;
    if ({bus_a.cycle_count, bus_a.halted_mask} !== 17'd0)
      $display("FAIL reset_a_cnt got %0d/%b want 0/0", bus_a.cycle_count, bus_a.halted_mask); else passed++;
    fl = fb(); total++;
    if (fl !== 5'b10000) $display("FAIL reset_b_flags got %b want %b", fl, 5'b10000); else passed++;
    total++;
    if ({bus_b.cycle_count, bus_b.halted_mask} !== 19'd0)
      $display("FAIL reset_b_cnt got %0d/%b want 0/0", bus_b.cycle_count, bus_b.halted_mask); else passed++;
  endtask

  task automatic test_single_halt();
    do_reset();
    bus_a.go = 1'b1; tick(1); bus_a.go = 1'b0;
    fl = fa(); total++;
    if (fl !== 5'b10000) $display("FAIL seq_rst1 got %b want %b", fl, 5'b10000); else passed++;
    tick(1);
    fl = fa(); total++;
    if (fl !== 5'b10000) $display("FAIL seq_rst2 got %b want %b", fl, 5'b10000); else passed++;
    tick(1);
    fl = fa(); total++;
    if (fl !== 5'b00000) $display("FAIL seq_arm got %b want %b", fl, 5'b00000); else passed++;
    tick(1);
    fl = fa(); total++;
    if (fl !== 5'b01100 || bus_a.cycle_count !== 16'd0)
      $display("FAIL seq_run1 got %b/%0d want 01100/0", fl, bus_a.cycle_count); else passed++;
    tick(39);
    total++;
    if (bus_a.cycle_count !== 16'd39) $display("FAIL seq_run40_cnt got %0d want 39", bus_a.cycle_count); else passed++;
    bus_a.halted = 1'b1; tick(1); bus_a.halted = 1'b0;
    fl = fa(); total++;
    if (fl !== 5'b00010 || bus_a.cycle_count !== 16'd40 || bus_a.halted_mask !== 1'b1)
      $display("FAIL seq_done got %b/%0d/%b want 00010/40/1", fl, bus_a.cycle_count, bus_a.halted_mask); else passed++;
    tick(2);
    fl = fa(); total++;
    if (fl !== 5'b00010 || bus_a.cycle_count !== 16'd40)
      $display("FAIL seq_done_frozen got %b/%0d want 00010/40", fl, bus_a.cycle_count); else passed++;
  endtask

  task automatic test_timeout();
    do_reset();
    start_b();
    tick(19);
    fl = fb(); total++;
    if (fl !== 5'b01100 || bus_b.cycle_count !== 16'd19)
      $display("FAIL to_run20 got %b/%0d want 01100/19", fl, bus_b.cycle_count); else passed++;
    tick(1);
    fl = fb(); total++;
    if (fl !== 5'b00011 || bus_b.cycle_count !== 16'd20 || bus_b.halted_mask !== 3'b000)
      $display("FAIL to_done got %b/%0d/%b want 00011/20/000", fl, bus_b.cycle_count, bus_b.halted_mask); else passed++;
    tick(3);
    fl = fb(); total++;
    if (fl !== 5'b00011 || bus_b.cycle_count !== 16'd20)
      $display("FAIL to_frozen got %b/%0d want 00011/20", fl, bus_b.cycle_count); else passed++;
  endtask

  task automatic test_multi_core();
    do_reset();
    start_b();
    tick(4);
    bus_b.halted = 3'b001; tick(1); bus_b.halted = 3'b000;
    fl = fb(); total++;
    if (fl !== 5'b01100 || bus_b.halted_mask !== 3'b001)
      $display("FAIL mc_mask1 got %b/%b want 01100/001", fl, bus_b.halted_mask); else passed++;
    tick(3);
    bus_b.halted = 3'b100; tick(1); bus_b.halted = 3'b000;
    total++;
    if (bus_b.halted_mask !== 3'b101 || bus_b.cycle_count !== 16'd9)
      $display("FAIL mc_mask2 got %b/%0d want 101/9", bus_b.halted_mask, bus_b.cycle_count); else passed++;
    bus_b.halted = 3'b001; tick(1); bus_b.halted = 3'b000; tick(1);
    bus_b.halted = 3'b001; tick(1); bus_b.halted = 3'b000;
    fl = fb(); total++;
    if (fl !== 5'b01100 || bus_b.halted_mask !== 3'b101 || bus_b.cycle_count !== 16'd12)
      $display("FAIL mc_repeat got %b/%b/%0d want 01100/101/12", fl, bus_b.halted_mask, bus_b.cycle_count); else passed++;
    tick(1);
    bus_b.halted = 3'b010; tick(1); bus_b.halted = 3'b000;
    fl = fb(); total++;
    if (fl !== 5'b00010 || bus_b.cycle_count !== 16'd14 || bus_b.halted_mask !== 3'b111)
      $display("FAIL mc_done got %b/%0d/%b want 00010/14/111", fl, bus_b.cycle_count, bus_b.halted_mask); else passed++;
  endtask

  task automatic test_last_halt();
    do_reset();
    start_b();
    tick(4);
    bus_b.halted = 3'b011; tick(1); bus_b.halted = 3'b000;
    tick(14);
    fl = fb(); total++;
    if (fl !== 5'b01100 || bus_b.cycle_count !== 16'd19)
      $display("FAIL lh_run20 got %b/%0d want 01100/19", fl, bus_b.cycle_count); else passed++;
    bus_b.halted = 3'b100; tick(1); bus_b.halted = 3'b000;
    fl = fb(); total++;
    if (fl !== 5'b00010 || bus_b.cycle_count !== 16'd20 || bus_b.halted_mask !== 3'b111)
      $display("FAIL lh_done got %b/%0d/%b want 00010/20/111", fl, bus_b.cycle_count, bus_b.halted_mask); else passed++;
  endtask

  task automatic test_mid_reset();
    do_reset();
    start_a();
    tick(6);
    total++;
    if (bus_a.cycle_count !== 16'd6) $display("FAIL mr_run7_cnt got %0d want 6", bus_a.cycle_count); else passed++;
    bus_a.halted = 1'b1; rst = 1'b1; tick(1); rst = 1'b0; bus_a.halted = 1'b0;
    fl = fa(); total++;
    if (fl !== 5'b10000 || bus_a.cycle_count !== 16'd0 || bus_a.halted_mask !== 1'b0)
      $display("FAIL mr_idle got %b/%0d/%b want 10000/0/0", fl, bus_a.cycle_count, bus_a.halted_mask); else passed++;
    tick(2);
    fl = fa(); total++;
    if (fl !== 5'b10000) $display("FAIL mr_stay_idle got %b want 10000", fl); else passed++;
    start_a();
    tick(2);
    bus_a.halted = 1'b1; tick(1); bus_a.halted = 1'b0;
    fl = fa(); total++;
    if (fl !== 5'b00010 || bus_a.cycle_count !== 16'd3 || bus_a.halted_mask !== 1'b1)
      $display("FAIL mr_rerun got %b/%0d/%b want 00010/3/1", fl, bus_a.cycle_count, bus_a.halted_mask); else passed++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus_b.go = 1'b1; tick(4);
    fl = fb(); total++;
    if (fl !== 5'b01100) $display("FAIL bb_run1 got %b want 01100", fl); else passed++;
    bus_b.go = 1'b0; tick(1); bus_b.go = 1'b1; tick(1);
    fl = fb(); total++;
    if (fl !== 5'b01100 || bus_b.cycle_count !== 16'd2)
      $display("FAIL bb_go_toggle got %b/%0d want 01100/2", fl, bus_b.cycle_count); else passed++;
    bus_b.halted = 3'b111; tick(1); bus_b.halted = 3'b000;
    fl = fb(); total++;
    if (fl !== 5'b00010 || bus_b.cycle_count !== 16'd3 || bus_b.halted_mask !== 3'b111)
      $display("FAIL bb_done1 got %b/%0d/%b want 00010/3/111", fl, bus_b.cycle_count, bus_b.halted_mask); else passed++;
    tick(1);
    fl = fb(); total++;
    if (fl !== 5'b10000 || bus_b.cycle_count !== 16'd0 || bus_b.halted_mask !== 3'b000)
      $display("FAIL bb_rst_entry got %b/%0d/%b want 10000/0/000", fl, bus_b.cycle_count, bus_b.halted_mask); else passed++;
    tick(2);
    fl = fb(); total++;
    if (fl !== 5'b00000) $display("FAIL bb_arm got %b want 00000", fl); else passed++;
    tick(1);
    fl = fb(); total++;
    if (fl !== 5'b01100 || bus_b.cycle_count !== 16'd0)
      $display("FAIL bb_run1b got %b/%0d want 01100/0", fl, bus_b.cycle_count); else passed++;
    bus_b.go = 1'b0; tick(3);
    fl = fb(); total++;
    if (fl !== 5'b01100 || bus_b.cycle_count !== 16'd3)
      $display("FAIL bb_run4b got %b/%0d want 01100/3", fl, bus_b.cycle_count); else passed++;
    bus_b.go = 1'b1; tick(1); bus_b.go = 1'b0; tick(1);
    bus_b.halted = 3'b111; tick(1); bus_b.halted = 3'b000;
    fl = fb(); total++;
    if (fl !== 5'b00010 || bus_b.cycle_count !== 16'd6)
      $display("FAIL bb_done2 got %b/%0d want 00010/6", fl, bus_b.cycle_count); else passed++;
    tick(2);
    fl = fb(); total++;
    if (fl !== 5'b00010) $display("FAIL bb_done_hold got %b want 00010", fl); else passed++;
  endtask

  initial begin
    test_reset();
    test_single_halt();
    test_timeout();
    test_multi_core();
    test_last_halt();
    test_mid_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
